// File: rtl/frame_capture_ctrl.sv
// Frame capture sequencer: aligns to a frame boundary, discards skip_frames frames, then forwards
// num_frames whole frames with one cycle of latency and checks their line/frame geometry.
module frame_capture_ctrl #(
  parameter int WIDTH      = 640,
  parameter int HEIGHT     = 512,
  parameter int DATA_WIDTH = 12,
  parameter int CNT_W      = 8
) (
  input  logic                  pix_clk,
  input  logic                  rstb,
  input  logic                  start,
  input  logic                  abort,
  input  logic [CNT_W-1:0]      num_frames,
  input  logic [CNT_W-1:0]      skip_frames,
  input  logic                  clear_err,
  input  logic                  fval,
  input  logic                  lval,
  input  logic                  dval,
  input  logic [DATA_WIDTH-1:0] pix_data,
  output logic                  out_fval,
  output logic                  out_lval,
  output logic                  out_dval,
  output logic [DATA_WIDTH-1:0] out_pix_data,
  output logic                  busy,
  output logic                  done,
  output logic [CNT_W-1:0]      frame_cnt,
  output logic                  err_line_len,
  output logic                  err_frame_len
);

  localparam logic [15:0] WIDTH_C  = 16'(WIDTH);
  localparam logic [15:0] HEIGHT_C = 16'(HEIGHT);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ARM      = 3'd1,
    ST_WAIT_SOF = 3'd2,
    ST_SKIP     = 3'd3,
    ST_CAPTURE  = 3'd4,
    ST_DONE     = 3'd5
  } state_t;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    if (v == 16'hFFFF) begin
      return v;
    end else begin
      return v + 16'd1;
    end
  endfunction

  state_t                  state_r;
  logic [CNT_W-1:0]        num_r;
  logic [CNT_W-1:0]        skip_rem_r;
  logic [CNT_W-1:0]        frame_cnt_r;
  logic                    busy_r;
  logic                    done_r;
  logic                    out_fval_r;
  logic                    out_lval_r;
  logic                    out_dval_r;
  logic [DATA_WIDTH-1:0]   out_pix_r;
  logic                    fval_d_r;
  logic                    lval_d_r;
  logic                    abort_kill_r;
  logic [15:0]             pix_cnt_r;
  logic [15:0]             line_cnt_r;
  logic                    err_line_r;
  logic                    err_frame_r;

  logic                    cap_en_s;
  logic [CNT_W:0]          cnt_next_s;
  logic                    last_frame_s;
  logic                    line_fall_s;
  logic                    frame_fall_s;
  logic [15:0]             lines_at_end_s;
  logic                    line_err_s;
  logic                    frame_err_s;

  // Forwarding window: the whole capture frame, or the very first cycle of a frame when no skips remain
  always_comb begin
    cap_en_s = 1'b0;
    if (abort) begin
      cap_en_s = 1'b0;
    end else if (state_r == ST_CAPTURE) begin
      cap_en_s = 1'b1;
    end else if ((state_r == ST_WAIT_SOF) && fval && (skip_rem_r == {CNT_W{1'b0}})) begin
      cap_en_s = 1'b1;
    end else begin
      cap_en_s = 1'b0;
    end
  end

  // Frame count lookahead; one extra bit so num_frames at full scale still compares cleanly
  always_comb begin
    cnt_next_s   = {1'b0, frame_cnt_r} + {{CNT_W{1'b0}}, 1'b1};
    last_frame_s = (cnt_next_s == {1'b0, num_r});
  end

  // Capture sequencer with registered busy/done/frame_cnt
  always_ff @(posedge pix_clk or negedge rstb) begin
    if (!rstb) begin
      state_r     <= ST_IDLE;
      num_r       <= {CNT_W{1'b0}};
      skip_rem_r  <= {CNT_W{1'b0}};
      frame_cnt_r <= {CNT_W{1'b0}};
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      done_r <= 1'b0;
      if (abort && (state_r != ST_IDLE)) begin
        state_r <= ST_IDLE;
        busy_r  <= 1'b0;
      end else begin
        case (state_r)
          ST_IDLE: begin
            if (start && !abort) begin
              num_r       <= num_frames;
              skip_rem_r  <= skip_frames;
              frame_cnt_r <= {CNT_W{1'b0}};
              busy_r      <= 1'b1;
              if (num_frames == {CNT_W{1'b0}}) begin
                state_r <= ST_DONE;
                done_r  <= 1'b1;
              end else begin
                state_r <= ST_ARM;
              end
            end
          end
          ST_ARM: begin
            if (!fval) begin
              state_r <= ST_WAIT_SOF;
            end
          end
          ST_WAIT_SOF: begin
            if (fval) begin
              state_r <= (skip_rem_r != {CNT_W{1'b0}}) ? ST_SKIP : ST_CAPTURE;
            end
          end
          ST_SKIP: begin
            if (!fval) begin
              skip_rem_r <= skip_rem_r - {{(CNT_W-1){1'b0}}, 1'b1};
              state_r    <= ST_WAIT_SOF;
            end
          end
          ST_CAPTURE: begin
            if (!fval) begin
              frame_cnt_r <= cnt_next_s[CNT_W-1:0];
              if (last_frame_s) begin
                state_r <= ST_DONE;
                done_r  <= 1'b1;
              end else begin
                state_r <= ST_WAIT_SOF;
              end
            end
          end
          ST_DONE: begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
          end
          default: begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
          end
        endcase
      end
    end
  end

  // Gated, one-cycle-delayed video towards the grabber
  always_ff @(posedge pix_clk or negedge rstb) begin
    if (!rstb) begin
      out_fval_r <= 1'b0;
      out_lval_r <= 1'b0;
      out_dval_r <= 1'b0;
      out_pix_r  <= {DATA_WIDTH{1'b0}};
    end else begin
      out_fval_r <= fval & cap_en_s;
      out_lval_r <= lval & cap_en_s;
      out_dval_r <= dval & cap_en_s;
      out_pix_r  <= (dval & cap_en_s) ? pix_data : {DATA_WIDTH{1'b0}};
    end
  end

  // Edge detection on the forwarded stream; an abort-induced frame end is not judged
  always_comb begin
    line_fall_s    = lval_d_r & ~out_lval_r;
    frame_fall_s   = fval_d_r & ~out_fval_r;
    lines_at_end_s = line_fall_s ? sat_inc(line_cnt_r) : line_cnt_r;
    line_err_s     = line_fall_s & ~abort_kill_r & (pix_cnt_r != WIDTH_C);
    frame_err_s    = frame_fall_s & ~abort_kill_r & (lines_at_end_s != HEIGHT_C);
  end

  // Saturating pixel-per-line and line-per-frame counters over forwarded video
  always_ff @(posedge pix_clk or negedge rstb) begin
    if (!rstb) begin
      fval_d_r     <= 1'b0;
      lval_d_r     <= 1'b0;
      abort_kill_r <= 1'b0;
      pix_cnt_r    <= 16'd0;
      line_cnt_r   <= 16'd0;
    end else begin
      fval_d_r     <= out_fval_r;
      lval_d_r     <= out_lval_r;
      abort_kill_r <= abort & (state_r != ST_IDLE);
      if (abort_kill_r) begin
        pix_cnt_r  <= 16'd0;
        line_cnt_r <= 16'd0;
      end else begin
        if (line_fall_s) begin
          pix_cnt_r <= 16'd0;
        end else if (out_dval_r) begin
          pix_cnt_r <= sat_inc(pix_cnt_r);
        end
        if (frame_fall_s) begin
          line_cnt_r <= 16'd0;
        end else if (line_fall_s) begin
          line_cnt_r <= sat_inc(line_cnt_r);
        end
      end
    end
  end

  // Sticky geometry flags; a new error in the clearing cycle keeps the flag set
  always_ff @(posedge pix_clk or negedge rstb) begin
    if (!rstb) begin
      err_line_r  <= 1'b0;
      err_frame_r <= 1'b0;
    end else begin
      err_line_r  <= line_err_s | (err_line_r & ~clear_err);
      err_frame_r <= frame_err_s | (err_frame_r & ~clear_err);
    end
  end

  assign out_fval      = out_fval_r;
  assign out_lval      = out_lval_r;
  assign out_dval      = out_dval_r;
  assign out_pix_data  = out_pix_r;
  assign busy          = busy_r;
  assign done          = done_r;
  assign frame_cnt     = frame_cnt_r;
  assign err_line_len  = err_line_r;
  assign err_frame_len = err_frame_r;

endmodule

// File: tb/tb_frame_capture_ctrl.sv
// Bench for frame_capture_ctrl: table-driven episodes and random episodes checked cycle by cycle
// against a frame-level model, plus directed abort / reset / start-while-busy sequences.
module tb_frame_capture_ctrl;
  localparam int W  = 8;
  localparam int H  = 4;
  localparam int DW = 12;
  localparam int CW = 8;

  logic          pix_clk = 1'b0;
  logic          rstb = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          clear_err = 1'b0;
  logic [CW-1:0] num_frames = '0;
  logic [CW-1:0] skip_frames = '0;
  logic          fval = 1'b0;
  logic          lval = 1'b0;
  logic          dval = 1'b0;
  logic [DW-1:0] pix_data = '0;
  logic          out_fval, out_lval, out_dval;
  logic [DW-1:0] out_pix_data;
  logic          busy, done;
  logic [CW-1:0] frame_cnt;
  logic          err_line_len, err_frame_len;

  frame_capture_ctrl #(.WIDTH(W), .HEIGHT(H), .DATA_WIDTH(DW), .CNT_W(CW)) dut (
    .pix_clk(pix_clk), .rstb(rstb), .start(start), .abort(abort),
    .num_frames(num_frames), .skip_frames(skip_frames), .clear_err(clear_err),
    .fval(fval), .lval(lval), .dval(dval), .pix_data(pix_data),
    .out_fval(out_fval), .out_lval(out_lval), .out_dval(out_dval), .out_pix_data(out_pix_data),
    .busy(busy), .done(done), .frame_cnt(frame_cnt),
    .err_line_len(err_line_len), .err_frame_len(err_frame_len)
  );

  always #5 pix_clk = ~pix_clk;

  typedef struct {
    logic          f;
    logic          l;
    logic          d;
    logic [DW-1:0] p;
  } cyc_t;

  typedef struct {
    int   num;
    int   skip;
    int   s;
    int   bad_f;
    int   bad_k;
    logic exp_el;
    logic exp_ef;
    int   exp_fc;
    int   exp_done;
  } vec_t;

  cyc_t stim[$];
  int   n_tests = 0;
  int   n_fail = 0;
  int   fc_prev = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge pix_clk);
    #1;
  endtask

  task automatic drive(input logic f, input logic l, input logic d);
    fval = f; lval = l; dval = d; pix_data = DW'($urandom);
    step();
  endtask

  // Source stream: 7 frames, each line followed by 2 blank cycles, 2 cycles between frames
  task automatic build_stream(input int bad_f, input int bad_k, input bit rnd);
    int nl, np;
    stim.delete();
    for (int i = 0; i < 3; i++) stim.push_back('{1'b0, 1'b0, 1'b0, DW'($urandom)});
    for (int f = 0; f < 7; f++) begin
      nl = H;
      if (rnd) begin
        if ($urandom_range(0, 3) == 0) nl = $urandom_range(3, 5);
      end else if (f == bad_f && bad_k == 2) nl = 3;
      for (int l = 0; l < nl; l++) begin
        np = W;
        if (rnd) begin
          if ($urandom_range(0, 5) == 0) np = $urandom_range(7, 9);
        end else if (f == bad_f && bad_k == 1 && l == 1) np = 7;
        for (int p = 0; p < np; p++) stim.push_back('{1'b1, 1'b1, 1'b1, DW'($urandom)});
        for (int b = 0; b < 2; b++) stim.push_back('{1'b1, 1'b0, 1'b0, DW'($urandom)});
      end
      for (int b = 0; b < 2; b++) stim.push_back('{1'b0, 1'b0, 1'b0, DW'($urandom)});
    end
    for (int i = 0; i < 6; i++) stim.push_back('{1'b0, 1'b0, 1'b0, DW'($urandom)});
  endtask

  // Plays stim with a start at cycle s, then compares every cycle with the frame-level model
  task automatic run_episode(input string tag, input int num, input int skip, input int s,
                             output int done_seen);
    logic [24:0] obs[$];
    logic [24:0] ex;
    int rises[$], fr[$], ff[$];
    int n, j, f, last, cnt, dc, lines;
    logic el, ef;
    logic e_f, e_l, e_d, e_busy, e_done;
    logic [DW-1:0] e_p;
    logic [CW-1:0] e_fc;

    clear_err = 1'b1; step(); clear_err = 1'b0;
    check({tag, " clr_line"}, err_line_len, 1'b0);
    check({tag, " clr_frame"}, err_frame_len, 1'b0);
    n = stim.size();
    for (int k = 0; k < n; k++) begin
      fval = stim[k].f; lval = stim[k].l; dval = stim[k].d; pix_data = stim[k].p;
      start       = (k == s);
      num_frames  = (k == s) ? CW'(num)  : CW'($urandom);
      skip_frames = (k == s) ? CW'(skip) : CW'($urandom);
      step();
      obs.push_back({out_fval, out_lval, out_dval, out_pix_data, busy, done, frame_cnt});
    end
    start = 1'b0; fval = 1'b0; lval = 1'b0; dval = 1'b0; pix_data = '0;

    // Model: align on the first fval-low cycle after start, skip whole frames, forward the rest
    if (num > 0) begin
      j = n;
      for (int k = s + 1; k < n; k++) if (!stim[k].f) begin j = k; break; end
      for (int k = j + 1; k < n; k++) if (stim[k].f && !stim[k-1].f) rises.push_back(k);
      check({tag, " stream_frames"}, 32'(rises.size() >= skip + num), 32'd1);
      for (int i = skip; i < skip + num && i < rises.size(); i++) begin
        f = rises[i];
        while (f < n && stim[f].f) f++;
        fr.push_back(rises[i]);
        ff.push_back(f);
      end
    end
    last = (num == 0) ? s : ((ff.size() > 0) ? ff[ff.size()-1] : n);

    done_seen = 0;
    for (int k = 0; k < n; k++) begin
      e_f = 1'b0; e_l = 1'b0; e_d = 1'b0; e_p = '0;
      for (int i = 0; i < fr.size(); i++) begin
        if (k >= fr[i] && k <= ff[i]) begin
          e_f = stim[k].f; e_l = stim[k].l; e_d = stim[k].d;
          e_p = stim[k].d ? stim[k].p : '0;
        end
      end
      e_busy = (k >= s) && (k <= last);
      e_done = (k == last);
      cnt = 0;
      foreach (ff[i]) if (ff[i] <= k) cnt++;
      e_fc = (k < s) ? CW'(fc_prev) : CW'(cnt);
      ex = {e_f, e_l, e_d, e_p, e_busy, e_done, e_fc};
      check($sformatf("%s cyc%0d {fval,lval,dval,pix,busy,done,cnt}", tag, k), obs[k], ex);
      if (obs[k][8]) done_seen++;
    end

    el = 1'b0; ef = 1'b0;
    for (int i = 0; i < fr.size(); i++) begin
      dc = 0; lines = 0;
      for (int k = fr[i]; k <= ff[i] && k < n; k++) begin
        if (k > fr[i] && stim[k-1].l && !stim[k].l) begin
          if (dc != W) el = 1'b1;
          lines++;
          dc = 0;
        end
        if (stim[k].d) dc++;
      end
      if (lines != H) ef = 1'b1;
    end
    check({tag, " err_line_model"}, err_line_len, el);
    check({tag, " err_frame_model"}, err_frame_len, ef);
    fc_prev = ff.size();
  endtask

  initial begin
    vec_t vecs[6];
    int   ds;
    logic bad;

    vecs[0] = '{2, 1, 10, -1, 0, 1'b0, 1'b0, 2, 1};
    vecs[1] = '{0, 0, 5,  -1, 0, 1'b0, 1'b0, 0, 1};
    vecs[2] = '{1, 0, 1,   0, 1, 1'b1, 1'b0, 1, 1};
    vecs[3] = '{1, 1, 1,   0, 2, 1'b0, 1'b0, 1, 1};
    vecs[4] = '{2, 0, 1,   1, 2, 1'b0, 1'b1, 2, 1};
    vecs[5] = '{3, 2, 60,  3, 1, 1'b0, 1'b0, 3, 1};

    rstb = 1'b0;
    repeat (3) @(posedge pix_clk);
    #1;
    check("reset outputs", {out_fval, out_lval, out_dval, out_pix_data, busy, done, frame_cnt,
                            err_line_len, err_frame_len}, 32'd0);
    @(negedge pix_clk);
    rstb = 1'b1;
    step();
    check("idle after reset", {busy, done, out_fval}, 32'd0);

    for (int i = 0; i < 6; i++) begin
      build_stream(vecs[i].bad_f, vecs[i].bad_k, 1'b0);
      run_episode($sformatf("vec%0d", i), vecs[i].num, vecs[i].skip, vecs[i].s, ds);
      check($sformatf("vec%0d err_line", i), err_line_len, vecs[i].exp_el);
      check($sformatf("vec%0d err_frame", i), err_frame_len, vecs[i].exp_ef);
      check($sformatf("vec%0d frame_cnt", i), frame_cnt, vecs[i].exp_fc);
      check($sformatf("vec%0d done_pulses", i), ds, vecs[i].exp_done);
    end

    for (int i = 0; i < 8; i++) begin
      build_stream(-1, 0, 1'b1);
      run_episode($sformatf("rnd%0d", i), $urandom_range(0, 3), $urandom_range(0, 2),
                  $urandom_range(0, 50), ds);
      check($sformatf("rnd%0d done_pulses", i), ds, 32'd1);
    end

    // Start while busy ignored, then abort in line 2 of the second captured frame
    num_frames = 8'd2; skip_frames = 8'd0; start = 1'b1;
    drive(1'b0, 1'b0, 1'b0);
    start = 1'b0;
    check("abort_seq busy", busy, 1'b1);
    drive(1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0);
    for (int l = 0; l < H; l++) begin
      for (int p = 0; p < W; p++) begin
        if (l == 0 && p == 3) begin start = 1'b1; num_frames = 8'd0; end
        drive(1'b1, 1'b1, 1'b1);
        if (start) begin
          start = 1'b0;
          check("busy start ignored done", done, 1'b0);
          check("busy start ignored busy", busy, 1'b1);
        end
      end
      drive(1'b1, 1'b0, 1'b0);
      drive(1'b1, 1'b0, 1'b0);
    end
    drive(1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0);
    check("abort_seq first frame cnt", frame_cnt, 8'd1);
    check("abort_seq still busy", busy, 1'b1);
    for (int p = 0; p < W; p++) drive(1'b1, 1'b1, 1'b1);
    drive(1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b1);
    drive(1'b1, 1'b1, 1'b1);
    check("abort_seq forwarding", out_fval, 1'b1);
    abort = 1'b1;
    drive(1'b1, 1'b1, 1'b1);
    abort = 1'b0;
    check("abort out_fval", out_fval, 1'b0);
    check("abort out_dval", out_dval, 1'b0);
    check("abort busy", busy, 1'b0);
    check("abort done", done, 1'b0);
    check("abort frame_cnt holds", frame_cnt, 8'd1);
    bad = 1'b0;
    for (int p = 3; p < W; p++) begin
      drive(1'b1, 1'b1, 1'b1);
      if (out_fval || done || busy) bad = 1'b1;
    end
    for (int l = 2; l < H; l++) begin
      for (int p = 0; p < W + 2; p++) begin
        drive(1'b1, (p < W), (p < W));
        if (out_fval || done || busy) bad = 1'b1;
      end
    end
    drive(1'b0, 1'b0, 1'b0);
    if (out_fval || done || busy) bad = 1'b1;
    check("after abort quiet", bad, 1'b0);
    num_frames = 8'd0; start = 1'b1;
    drive(1'b0, 1'b0, 1'b0);
    start = 1'b0;
    check("restart num0 busy", busy, 1'b1);
    check("restart num0 done", done, 1'b1);
    check("restart num0 frame_cnt", frame_cnt, 8'd0);
    drive(1'b0, 1'b0, 1'b0);
    check("restart num0 back idle", {busy, done}, 32'd0);

    // Start and abort together in IDLE
    num_frames = 8'd1; start = 1'b1; abort = 1'b1;
    drive(1'b0, 1'b0, 1'b0);
    start = 1'b0; abort = 1'b0;
    check("start+abort idle busy", busy, 1'b0);
    drive(1'b0, 1'b0, 1'b0);
    check("start+abort idle busy2", busy, 1'b0);

    // Reset asserted mid-capture
    num_frames = 8'd1; start = 1'b1;
    drive(1'b0, 1'b0, 1'b0);
    start = 1'b0;
    drive(1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b1);
    drive(1'b1, 1'b1, 1'b1);
    check("pre-reset capturing", {out_fval, out_dval, busy}, 32'd7);
    rstb = 1'b0;
    #1;
    check("mid-capture reset outputs", {out_fval, out_lval, out_dval, out_pix_data, busy, done,
                                        frame_cnt}, 32'd0);
    @(negedge pix_clk);
    rstb = 1'b1;
    bad = 1'b0;
    for (int p = 0; p < 6; p++) begin
      drive(1'b1, 1'b1, 1'b1);
      if (out_fval || out_dval || busy || done) bad = 1'b1;
    end
    check("after reset idle", bad, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
